// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding, default width and counter sizing for the serial adder.
package serial_add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int DEFAULT_WIDTH = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/full_adder_1bit.sv
// full_adder_1bit: combinational one-bit full adder slice.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_4bit.sv
// serial_adder_4bit: bit-serial S = A + B + Cin, LSB first, one bit per clock.
// Optional signed overflow output ovf when SERIAL_ADD_OVF_EN is defined.
module serial_adder_4bit
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);
  localparam int CW = clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, w_shift;
  logic [WIDTH-2:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, w_sum, w_cout, w_accept, w_last;
  full_adder_1bit u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );
  assign busy     = r_state == ST_ADD;
  assign done     = r_state == ST_DONE;
  assign w_accept = start && !busy;
  assign w_last   = busy && r_cnt == CW'(WIDTH - 1);
  // new sum bit enters at the MSB; after WIDTH steps the first bit sits at bit 0
  assign w_shift  = {w_sum, r_s};
  always_comb begin
    w_next = r_state;
    w_next = busy ? (w_last ? ST_DONE : ST_ADD) : (w_accept ? ST_ADD : ST_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_carry <= Cin;
        r_cnt   <= '0;
      end else if (busy) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_s     <= w_shift[WIDTH-1:1];
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          S    <= w_shift;
          Cout <= w_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf  <= r_carry ^ w_cout;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_4bit.sv
// tb_serial_adder_4bit: directed self-checking bench for serial_adder_4bit (WIDTH 4 and 8).
module tb_serial_adder_4bit;
  logic       clk = 0, rst_n = 0, start = 0, Cin = 0;
  logic [3:0] A = 0, B = 0, S;
  logic       Cout, busy, done;
  logic       start8 = 0;
  logic [7:0] A8 = 0, B8 = 0, S8;
  logic       Cout8, busy8, done8;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf, ovf8;
`endif
  int         n_chk = 0, n_pass = 0, cyc = 0, nbusy = 0, t_start = 0, t_done = 0, t1 = 0;
  logic [3:0] s_prev = 0;
  bit         excl_ok = 1;
  serial_adder_4bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .S(S), .Cout(Cout), .busy(busy),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf),
`endif
    .done(done)
  );
  serial_adder_4bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .Cin(1'b0),
    .S(S8), .Cout(Cout8), .busy(busy8),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf8),
`endif
    .done(done8)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (busy) nbusy++;
  end
  always @(negedge clk) if ((busy && done) || (busy8 && done8)) excl_ok = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1;
    s_prev = S;
    nbusy = 0;
    @(negedge clk);
    start = 0;
    t_start = cyc;
  endtask
  task automatic finish(input string tag, input logic [3:0] es, input logic ec);
    bit held = 1;
    int i = 0;
    while (!done && i < 40) begin
      if (S !== s_prev) held = 0;
      @(negedge clk);
      i++;
    end
    t_done = cyc;
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " latency"}, t_done - t_start, 4);
    chk({tag, " busy cycles"}, nbusy, 4);
    chk({tag, " S"}, 32'(S), 32'(es));
    chk({tag, " Cout"}, 32'(Cout), 32'(ec));
    chk({tag, " S held"}, 32'(held), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset S", 32'(S), 0);
    chk("reset Cout", 32'(Cout), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    rst_n = 1;
    launch(4'b0111, 4'b0010, 0);
    finish("t1", 4'b1001, 0);
    @(negedge clk);
    chk("t1 done pulse", 32'(done), 0);
    launch(4'b1111, 4'b0001, 0);
    finish("t2a", 4'b0000, 1);
    launch(4'b0100, 4'b0100, 1);
    finish("t2b", 4'b1001, 0);
    launch(4'b0011, 4'b0001, 0);
    @(negedge clk);
    A = 4'b1111; B = 4'b1111; Cin = 1; start = 1;
    @(negedge clk);
    start = 0;
    finish("t3", 4'b0100, 0);
    launch(4'b1000, 4'b0010, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("t4 S", 32'(S), 0);
    chk("t4 Cout", 32'(Cout), 0);
    chk("t4 busy", 32'(busy), 0);
    chk("t4 done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1;
    launch(4'b0001, 4'b0001, 0);
    finish("t4 after", 4'b0010, 0);
    launch(4'b0110, 4'b0011, 0);
    finish("t5 first", 4'b1001, 0);
    A = 4'b0101; B = 4'b0101; Cin = 0; start = 1;
    t1 = cyc;
    s_prev = S;
    nbusy = 0;
    @(negedge clk);
    start = 0;
    t_start = cyc;
    finish("t5 second", 4'b1010, 0);
    chk("t5 gap", t_done - t1, 5);
`ifdef SERIAL_ADD_OVF_EN
    launch(4'b0111, 4'b0001, 0);
    finish("t6a", 4'b1000, 0);
    chk("t6a ovf", 32'(ovf), 1);
    launch(4'b1111, 4'b0001, 0);
    finish("t6b", 4'b0000, 1);
    chk("t6b ovf", 32'(ovf), 0);
`endif
    @(negedge clk);
    A8 = 8'hFF; B8 = 8'h01; start8 = 1;
    @(negedge clk);
    start8 = 0;
    t1 = cyc;
    for (int i = 0; i < 40 && !done8; i++) @(negedge clk);
    chk("w8 done", 32'(done8), 1);
    chk("w8 latency", cyc - t1, 8);
    chk("w8 S", 32'(S8), 0);
    chk("w8 Cout", 32'(Cout8), 1);
`ifdef SERIAL_ADD_OVF_EN
    chk("w8 ovf", 32'(ovf8), 0);
`endif
    chk("busy/done exclusive", 32'(excl_ok), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
